// File: rtl/axi_node_pkg.sv
// Shared types and helpers for the AXI node schedulers.
package axi_node_pkg;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_HOLD = 1'b1
    } aw_state_e;

    // W-allocator ID entry width: {winner_bin, winner_onehot}.
    function automatic int axi_id_width(input int n_targ);
        return $clog2(n_targ) + n_targ;
    endfunction

endpackage

// File: rtl/axi_multiplexer.sv
// Binary-select N-input data multiplexer over a flat packed input bus.
module axi_multiplexer #(
    parameter int DATA_WIDTH = 64,
    parameter int N_IN       = 7,
    parameter int SEL_WIDTH  = $clog2(N_IN)
) (
    input  logic [N_IN*DATA_WIDTH-1:0] i_data,
    input  logic [SEL_WIDTH-1:0]       i_sel,
    output logic [DATA_WIDTH-1:0]      o_data
);

    always_comb begin
        o_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (i_sel == SEL_WIDTH'(i)) begin
                o_data = i_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/axi_rr_pick.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping at N_REQ-1.
module axi_rr_pick #(
    parameter int N_REQ = 7,
    parameter int LOG_N = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [LOG_N-1:0] i_ptr,
    output logic             o_valid,
    output logic [LOG_N-1:0] o_bin,
    output logic [N_REQ-1:0] o_onehot
);

    // One extra bit so ptr+k (at most 2*N_REQ-2) never overflows before the wrap.
    localparam int IW = LOG_N + 1;

    logic [IW-1:0] w_idx;

    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
        o_valid  = 1'b0;
        o_bin    = '0;
        o_onehot = '0;
        w_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = IW'(i_ptr) + IW'(k);
            if (w_idx >= IW'(N_REQ)) begin
                w_idx = w_idx - IW'(N_REQ);
            end
            if (!o_valid && i_req[w_idx[LOG_N-1:0]]) begin
                o_valid = 1'b1;
                o_bin   = w_idx[LOG_N-1:0];
            end
        end
        if (o_valid) begin
            o_onehot[o_bin] = 1'b1;
        end
    end

endmodule

// File: rtl/axi_aw_rr_scheduler.sv
// Round-robin AW scheduler: forwards one requester combinationally and pushes its ID
// into the W-allocator FIFO on every AW handshake.
module axi_aw_rr_scheduler
    import axi_node_pkg::*;
#(
    parameter int  N_TARG_PORT  = 7,
    parameter int  LOG_N_TARG   = $clog2(N_TARG_PORT),
    parameter int  AW_PAYLOAD_W = 64,
    localparam int ID_W         = axi_id_width(N_TARG_PORT)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [N_TARG_PORT-1:0]              aw_valid_i,
    input  logic [N_TARG_PORT*AW_PAYLOAD_W-1:0] aw_payload_i,
    output logic [N_TARG_PORT-1:0]              aw_ready_o,
    output logic                                aw_valid_o,
    output logic [AW_PAYLOAD_W-1:0]             aw_payload_o,
    input  logic                                aw_ready_i,
    output logic                                push_ID_o,
    output logic [ID_W-1:0]                     ID_o,
    input  logic                                grant_FIFO_ID_i
);

    aw_state_e             r_state;
    aw_state_e             w_state_nxt;
    logic [LOG_N_TARG-1:0] r_rr_ptr;
    logic [LOG_N_TARG-1:0] w_rr_ptr_nxt;
    logic [LOG_N_TARG-1:0] r_win;
    logic [LOG_N_TARG-1:0] w_win_nxt;
    logic                  r_en;

    logic                    w_pick_valid;
    logic [LOG_N_TARG-1:0]   w_pick_bin;
    logic [N_TARG_PORT-1:0]  w_pick_onehot;
    logic                    w_valid;
    logic [LOG_N_TARG-1:0]   w_sel;
    logic [N_TARG_PORT-1:0]  w_sel_onehot;
    logic [AW_PAYLOAD_W-1:0] w_mux_data;

    function automatic logic [LOG_N_TARG-1:0] f_next_ptr(input logic [LOG_N_TARG-1:0] idx);
        return (idx == LOG_N_TARG'(N_TARG_PORT - 1)) ? '0 : idx + LOG_N_TARG'(1);
    endfunction

    axi_rr_pick #(
        .N_REQ (N_TARG_PORT),
        .LOG_N (LOG_N_TARG)
    ) u_pick (
        .i_req    (aw_valid_i),
        .i_ptr    (r_rr_ptr),
        .o_valid  (w_pick_valid),
        .o_bin    (w_pick_bin),
        .o_onehot (w_pick_onehot)
    );

    axi_multiplexer #(
        .DATA_WIDTH (AW_PAYLOAD_W),
        .N_IN       (N_TARG_PORT),
        .SEL_WIDTH  (LOG_N_TARG)
    ) u_mux (
        .i_data (aw_payload_i),
        .i_sel  (w_sel),
        .o_data (w_mux_data)
    );

    // A new grant needs FIFO space; a held grant stays on its winner whatever else arrives.
    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_win_nxt    = r_win;
        w_valid      = 1'b0;
        w_sel        = w_pick_bin;
        w_sel_onehot = w_pick_onehot;
        if (r_en) begin
            unique case (r_state)
                ST_ARB: begin
                    if (w_pick_valid && grant_FIFO_ID_i) begin
                        w_valid = 1'b1;
                        if (aw_ready_i) begin
                            w_rr_ptr_nxt = f_next_ptr(w_pick_bin);
                        end else begin
                            w_win_nxt   = w_pick_bin;
                            w_state_nxt = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    w_sel               = r_win;
                    w_sel_onehot        = '0;
                    w_sel_onehot[r_win] = 1'b1;
                    w_valid             = aw_valid_i[r_win];
                    if (w_valid && aw_ready_i) begin
                        w_rr_ptr_nxt = f_next_ptr(r_win);
                        w_state_nxt  = ST_ARB;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_ARB;
            r_rr_ptr <= '0;
            r_win    <= '0;
            r_en     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_win    <= w_win_nxt;
            r_en     <= 1'b1;
        end
    end

    assign aw_valid_o   = w_valid;
    assign push_ID_o    = w_valid & aw_ready_i;
    assign aw_ready_o   = push_ID_o ? w_sel_onehot : '0;
    assign ID_o         = w_valid ? {w_sel, w_sel_onehot} : '0;
    assign aw_payload_o = w_valid ? w_mux_data : '0;

endmodule

// File: tb/tb_axi_aw_rr_scheduler.sv
// Bench for axi_aw_rr_scheduler: directed scenarios with literal expectations plus a
// per-cycle reference model, handshake/push scoreboard and starvation monitor.
module tb_axi_aw_rr_scheduler;

    localparam int N   = 7;
    localparam int LOG = 3;
    localparam int PW  = 64;
    localparam int IDW = 10;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   aw_valid_i;
    logic [N*PW-1:0] aw_payload_i;
    logic [N-1:0]   aw_ready_o;
    logic           aw_valid_o;
    logic [PW-1:0]  aw_payload_o;
    logic           aw_ready_i;
    logic           push_ID_o;
    logic [IDW-1:0] ID_o;
    logic           grant;

    always #5 clk = ~clk;

    axi_aw_rr_scheduler dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .aw_valid_i      (aw_valid_i),
        .aw_payload_i    (aw_payload_i),
        .aw_ready_o      (aw_ready_o),
        .aw_valid_o      (aw_valid_o),
        .aw_payload_o    (aw_payload_o),
        .aw_ready_i      (aw_ready_i),
        .push_ID_o       (push_ID_o),
        .ID_o            (ID_o),
        .grant_FIFO_ID_i (grant)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [IDW-1:0] id_of(input int idx);
        return {LOG'(idx), N'(1) << idx};
    endfunction

    // Reference model: pointer, optional locked winner, enable flag
    int           m_ptr;
    int           m_lock;
    bit           m_en;
    bit           m_locked;
    int           e_idx;
    bit           e_valid;
    bit           e_push;
    logic [N-1:0] e_rdy;
    logic [IDW-1:0] e_id;
    logic [N-1:0] hs_seen;
    bit           last_push;
    int           wait_cnt[N];
    int           hs_q[$];
    int           sb_idx;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs", 64'({aw_valid_o, push_ID_o, aw_ready_o, ID_o}), 64'd0);
            m_en      = 1'b0;
            m_locked  = 1'b0;
            m_ptr     = 0;
            m_lock    = 0;
            hs_seen   = '0;
            last_push = 1'b0;
            hs_q.delete();
            foreach (wait_cnt[i]) wait_cnt[i] = 0;
        end else begin
            e_valid = 1'b0;
            e_idx   = 0;
            if (m_en && m_locked) begin
                e_idx   = m_lock;
                e_valid = aw_valid_i[m_lock];
            end else if (m_en && grant) begin
                for (int k = 0; k < N; k++) begin
                    if (!e_valid && aw_valid_i[(m_ptr + k) % N]) begin
                        e_valid = 1'b1;
                        e_idx   = (m_ptr + k) % N;
                    end
                end
            end
            e_push = e_valid && aw_ready_i;
            e_id   = e_valid ? id_of(e_idx) : '0;
            e_rdy  = e_push ? N'(1) << e_idx : '0;

            check("model_aw_valid", 64'(aw_valid_o), 64'(e_valid));
            check("model_push", 64'(push_ID_o), 64'(e_push));
            check("model_ready", 64'(aw_ready_o), 64'(e_rdy));
            check("model_id", 64'(ID_o), 64'(e_id));
            if (e_valid) check("model_payload", aw_payload_o, aw_payload_i[e_idx*PW +: PW]);
            if (!m_en) check("disabled_payload", aw_payload_o, 64'd0);
            check("ready_at_most_one", 64'($countones(aw_ready_o) <= 1), 64'd1);
            check("push_needs_grant", 64'(push_ID_o && !grant), 64'd0);

            // Scoreboard: requester-side handshakes must match pushed IDs in order
            hs_seen = aw_ready_o & aw_valid_i;
            for (int i = 0; i < N; i++) begin
                if (hs_seen[i]) begin
                    check("starvation_bound", 64'(wait_cnt[i] <= N), 64'd1);
                    wait_cnt[i] = 0;
                    hs_q.push_back(i);
                end else if (!aw_valid_i[i]) begin
                    wait_cnt[i] = 0;
                end else if (hs_seen != '0) begin
                    wait_cnt[i]++;
                end
            end
            if (push_ID_o) begin
                if (hs_q.size() == 0) begin
                    check("sb_push_without_handshake", 64'd1, 64'd0);
                end else begin
                    sb_idx = hs_q.pop_front();
                    check("sb_id_order", 64'(ID_o), 64'(id_of(sb_idx)));
                end
            end
            last_push = push_ID_o;

            if (e_push) begin
                m_ptr    = (e_idx + 1) % N;
                m_locked = 1'b0;
            end else if (e_valid && !m_locked) begin
                m_locked = 1'b1;
                m_lock   = e_idx;
            end
            m_en = 1'b1;
        end
    end

    bit          pend[N];
    logic [63:0] pay[N];
    int          push_cnt;

    localparam logic [IDW-1:0] SEQ1 [8] = '{
        10'b000_0000001, 10'b001_0000010, 10'b010_0000100, 10'b011_0001000,
        10'b100_0010000, 10'b101_0100000, 10'b110_1000000, 10'b000_0000001
    };

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_payloads();
        for (int i = 0; i < N; i++) aw_payload_i[i*PW +: PW] = pay[i];
    endtask

    initial begin
        rst_n      = 1'b0;
        aw_valid_i = '0;
        aw_ready_i = 1'b0;
        grant      = 1'b1;
        for (int i = 0; i < N; i++) pay[i] = 64'h0123_4567_0000_0000 + 64'(i) * 64'h1_0001;
        drive_payloads();
        repeat (3) @(posedge clk);

        // 1: release with all requesting; first cycle silent, then 0..6,0
        tick();
        rst_n      = 1'b1;
        aw_valid_i = 7'h7F;
        aw_ready_i = 1'b1;
        #1 check("t1_cycle0_idle", 64'(aw_valid_o), 64'd0);
        for (int c = 0; c < 8; c++) begin
            tick();
            #1 check("t1_rr_id", 64'(ID_o), 64'(SEQ1[c]));
        end

        // 2: hold winner 1 for 4 cycles while port 0 rises; one push; next winner 4
        push_cnt = 0;
        tick();
        aw_valid_i = 7'b0010010;
        aw_ready_i = 1'b0;
        #1 check("t2_hold_id", 64'(ID_o), 64'(10'b001_0000010));
        push_cnt += int'(push_ID_o);
        tick();
        aw_valid_i = 7'b0010011;
        #1 check("t2_hold_id", 64'(ID_o), 64'(10'b001_0000010));
        push_cnt += int'(push_ID_o);
        tick();
        #1 check("t2_hold_id", 64'(ID_o), 64'(10'b001_0000010));
        push_cnt += int'(push_ID_o);
        tick();
        aw_ready_i = 1'b1;
        #1 check("t2_hold_id", 64'(ID_o), 64'(10'b001_0000010));
        check("t2_ready_o", 64'(aw_ready_o), 64'(7'b0000010));
        push_cnt += int'(push_ID_o);
        check("t2_single_push", 64'(push_cnt), 64'd1);
        tick();
        aw_valid_i = 7'b0010001;
        #1 check("t2_next_win", 64'(ID_o), 64'(10'b100_0010000));

        // 3: FIFO full blocks new grants; pointer (5) survives
        tick();
        aw_valid_i = 7'b1000001;
        grant      = 1'b0;
        #1 check("t3_blocked", 64'({aw_valid_o, aw_ready_o, push_ID_o}), 64'd0);
        for (int c = 0; c < 2; c++) begin
            tick();
            #1 check("t3_blocked", 64'({aw_valid_o, aw_ready_o, push_ID_o}), 64'd0);
        end
        tick();
        grant = 1'b1;
        #1 check("t3_resume_id", 64'(ID_o), 64'(10'b110_1000000));
        tick();
        aw_valid_i = 7'b0000001;
        #1 check("t3_port0_id", 64'(ID_o), 64'(10'b000_0000001));

        // 4: single requester 6, back-to-back pushes, pointer wraps to 0
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 0) aw_valid_i = 7'b1000000;
            #1 check("t4_b2b_id", 64'(ID_o), 64'(10'b110_1000000));
            check("t4_b2b_push", 64'(push_ID_o), 64'd1);
        end
        tick();
        aw_valid_i = 7'b1000001;
        #1 check("t4_wrap_id", 64'(ID_o), 64'(10'b000_0000001));

        // 5: async reset while holding winner 2
        tick();
        aw_valid_i = 7'b0000100;
        aw_ready_i = 1'b0;
        #1 check("t5_win_id", 64'(ID_o), 64'(10'b010_0000100));
        tick();
        #1 check("t5_holding", 64'(aw_valid_o), 64'd1);
        #1 rst_n = 1'b0;
        #1 check("t5_async_clear", 64'({aw_valid_o, push_ID_o, aw_ready_o, ID_o}), 64'd0);
        tick();
        tick();
        rst_n      = 1'b1;
        aw_valid_i = 7'h7F;
        aw_ready_i = 1'b1;
        #1 check("t5_cycle0_idle", 64'(aw_valid_o), 64'd0);
        tick();
        #1 check("t5_restart_port0", 64'(ID_o), 64'(10'b000_0000001));

        // 6: random AXI-compliant traffic; grant only falls right after a push
        for (int i = 0; i < N; i++) pend[i] = aw_valid_i[i];
        for (int cyc = 0; cyc < 10000; cyc++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (hs_seen[i]) pend[i] = 1'b0;
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    pay[i]  = {$urandom, $urandom};
                end
                aw_valid_i[i] = pend[i];
            end
            drive_payloads();
            aw_ready_i = ($urandom_range(0, 3) != 0);
            if (grant && last_push && $urandom_range(0, 3) == 0) grant = 1'b0;
            else if (!grant && $urandom_range(0, 2) == 0) grant = 1'b1;
        end
        tick();
        aw_valid_i = '0;
        grant      = 1'b1;
        repeat (3) tick();
        check("sb_leftover_handshakes", 64'(hs_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
